// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM/WB fields, formats load data and drives the register-file write port.
// Optional build macro WB_INSTRET_EN adds a 64-bit retired-instruction counter on InstretW.
module writeback_stage #(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              StallW,
   input  logic              FlushW,
   input  logic              ValidM,
   input  logic              RegWriteM,
   input  logic [REG_AW-1:0] RdM,
   input  logic [1:0]        ResultSrcM,
   input  logic [2:0]        Funct3M,
   input  logic [WIDTH-1:0]  ALUResultM,
   input  logic [WIDTH-1:0]  ReadDataM,
   input  logic [WIDTH-1:0]  PCPlus4M,
   input  logic [WIDTH-1:0]  ImmExtM,
   output logic              ValidW,
   output logic              RegWriteW,
   output logic [REG_AW-1:0] RdW,
   output logic [WIDTH-1:0]  ResultW
`ifdef WB_INSTRET_EN
   ,output logic [63:0]      InstretW
`endif
);

   localparam int OFFW = (WIDTH == 64) ? 3 : 2;

   localparam logic [1:0] SRC_ALU  = 2'b00;
   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;
   localparam logic [1:0] SRC_IMM  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   logic              valid_q;
   logic              regwrite_q;
   logic [REG_AW-1:0] rd_q;
   logic [1:0]        resultsrc_q;
   logic [2:0]        funct3_q;
   logic [WIDTH-1:0]  aluresult_q;
   logic [WIDTH-1:0]  readdata_q;
   logic [WIDTH-1:0]  pcplus4_q;
   logic [WIDTH-1:0]  immext_q;

   logic              load_en;

   assign load_en = !FlushW && !StallW;

   // Flush only kills valid/regwrite; the payload is held so ResultW stays quiet.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
         rd_q        <= '0;
         resultsrc_q <= 2'b00;
         funct3_q    <= 3'b000;
         aluresult_q <= '0;
         readdata_q  <= '0;
         pcplus4_q   <= '0;
         immext_q    <= '0;
      end else if (FlushW) begin
         valid_q     <= 1'b0;
         regwrite_q  <= 1'b0;
      end else if (load_en) begin
         valid_q     <= ValidM;
         regwrite_q  <= RegWriteM;
         rd_q        <= RdM;
         resultsrc_q <= ResultSrcM;
         funct3_q    <= Funct3M;
         aluresult_q <= ALUResultM;
         readdata_q  <= ReadDataM;
         pcplus4_q   <= PCPlus4M;
         immext_q    <= ImmExtM;
      end
   end

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         instret_q <= '0;
      end else if (load_en && ValidM) begin
         instret_q <= instret_q + 64'd1;
      end
   end

   assign InstretW = instret_q;
`endif

   logic [OFFW-1:0]  off_b;
   logic [OFFW-1:0]  off_h;
   logic [OFFW-1:0]  off_w;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      word_v;
   logic [WIDTH-1:0] load_fmt;

   always_comb begin
      off_b      = aluresult_q[OFFW-1:0];
      off_h      = off_b;
      off_h[0]   = 1'b0;
      off_w      = off_b;
      off_w[1:0] = 2'b00;
      byte_v     = readdata_q[{off_b, 3'b000} +: 8];
      half_v     = readdata_q[{off_h, 3'b000} +: 16];
      word_v     = readdata_q[{off_w, 3'b000} +: 32];
   end

   // For WIDTH=32 the word cases collapse to readdata, since off_w is always 0.
   always_comb begin
      load_fmt = readdata_q;
      case (funct3_q)
         F3_LB:   load_fmt = WIDTH'($signed(byte_v));
         F3_LBU:  load_fmt = WIDTH'(byte_v);
         F3_LH:   load_fmt = WIDTH'($signed(half_v));
         F3_LHU:  load_fmt = WIDTH'(half_v);
         F3_LW:   load_fmt = WIDTH'($signed(word_v));
         F3_LWU:  load_fmt = WIDTH'(word_v);
         F3_LD:   load_fmt = readdata_q;
         default: load_fmt = readdata_q;
      endcase
   end

   always_comb begin
      ResultW = aluresult_q;
      case (resultsrc_q)
         SRC_ALU:  ResultW = aluresult_q;
         SRC_LOAD: ResultW = load_fmt;
         SRC_PC4:  ResultW = pcplus4_q;
         SRC_IMM:  ResultW = immext_q;
         default:  ResultW = aluresult_q;
      endcase
   end

   assign ValidW    = valid_q;
   assign RdW       = rd_q;
   assign RegWriteW = regwrite_q && valid_q && (rd_q != '0);

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (WIDTH=32); counter checks run when WB_INSTRET_EN is defined.
module tb_writeback_stage;

   logic        clk;
   logic        rst;
   logic        StallW;
   logic        FlushW;
   logic        ValidM;
   logic        RegWriteM;
   logic [4:0]  RdM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM;
   logic [31:0] ReadDataM;
   logic [31:0] PCPlus4M;
   logic [31:0] ImmExtM;
   logic        ValidW;
   logic        RegWriteW;
   logic [4:0]  RdW;
   logic [31:0] ResultW;
`ifdef WB_INSTRET_EN
   logic [63:0] InstretW;
`endif

   int checks = 0;
   int errors = 0;

   writeback_stage #(.WIDTH(32), .REG_AW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .StallW     (StallW),
      .FlushW     (FlushW),
      .ValidM     (ValidM),
      .RegWriteM  (RegWriteM),
      .RdM        (RdM),
      .ResultSrcM (ResultSrcM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .ReadDataM  (ReadDataM),
      .PCPlus4M   (PCPlus4M),
      .ImmExtM    (ImmExtM),
      .ValidW     (ValidW),
      .RegWriteW  (RegWriteW),
      .RdW        (RdW),
      .ResultW    (ResultW)
`ifdef WB_INSTRET_EN
      ,.InstretW  (InstretW)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4, input logic [31:0] imm);
      ValidM = v; RegWriteM = rw; RdM = rd; ResultSrcM = src; Funct3M = f3;
      ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4; ImmExtM = imm;
   endtask

   task automatic test_reset();
      rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      drive(1'b1, 1'b1, 5'($urandom), 2'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      step();
      drive(1'b1, 1'b1, 5'd9, 2'b11, 3'($urandom), $urandom, $urandom, $urandom, 32'hDEAD0000);
      step();
      checks++;
      if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultW !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b we=%b rd=%0d res=%h, want 0 0 0 00000000",
                  ValidW, RegWriteW, RdW, ResultW);
      end
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (ValidW !== 1'b1 || RegWriteW !== 1'b1 || RdW !== 5'd3 || ResultW !== 32'h55) begin
         errors++;
         $display("FAIL reset_release: got valid=%b we=%b rd=%0d res=%h, want 1 1 3 00000055",
                  ValidW, RegWriteW, RdW, ResultW);
      end
   endtask

   task automatic test_load_format();
      logic [2:0]  f3  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010,
                               3'b000, 3'b100, 3'b001, 3'b111};
      logic [1:0]  off [9] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd2};
      logic [31:0] exp [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02,
                               32'h80F17F02, 32'h0000007F, 32'h00000002, 32'hFFFF80F1,
                               32'h80F17F02};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b1, 5'd4, 2'b01, f3[i], {30'h400, off[i]}, 32'h80F17F02,
               32'h0, 32'h0);
         step();
         checks++;
         if (ResultW !== exp[i]) begin
            errors++;
            $display("FAIL load_fmt[%0d] f3=%b off=%0d: got %h, want %h",
                     i, f3[i], off[i], ResultW, exp[i]);
         end
      end
   endtask

   task automatic test_source_mux();
      logic [1:0]  src [3] = '{2'b00, 2'b10, 2'b11};
      logic [31:0] exp [3] = '{32'h10, 32'h104, 32'hABCDE000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'd1, src[i], 3'b000, 32'h10, 32'h80F17F02, 32'h104, 32'hABCDE000);
         step();
         checks++;
         if (ResultW !== exp[i]) begin
            errors++;
            $display("FAIL src_mux[%0d] src=%b: got %h, want %h", i, src[i], ResultW, exp[i]);
         end
      end
   endtask

   task automatic test_x0_suppress();
      drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (RegWriteW !== 1'b0 || ValidW !== 1'b1) begin
         errors++;
         $display("FAIL x0_write: got we=%b valid=%b, want we=0 valid=1", RegWriteW, ValidW);
      end
      drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (RegWriteW !== 1'b1 || RdW !== 5'd5) begin
         errors++;
         $display("FAIL rd5_write: got we=%b rd=%0d, want we=1 rd=5", RegWriteW, RdW);
      end
      drive(1'b0, 1'b1, 5'd5, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (RegWriteW !== 1'b0 || ValidW !== 1'b0) begin
         errors++;
         $display("FAIL invalid_write: got we=%b valid=%b, want we=0 valid=0", RegWriteW, ValidW);
      end
   endtask

   task automatic test_stall_flush();
      drive(1'b1, 1'b1, 5'd7, 2'b00, 3'b000, 32'h77, 32'h0, 32'h0, 32'h0);
      step();
      StallW = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'(10 + i), 2'b11, 3'b000, 32'h99, 32'h0, 32'h0, 32'h1234);
         step();
         checks++;
         if (ValidW !== 1'b1 || RegWriteW !== 1'b1 || RdW !== 5'd7 || ResultW !== 32'h77) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got valid=%b we=%b rd=%0d res=%h, want 1 1 7 00000077",
                     i, ValidW, RegWriteW, RdW, ResultW);
         end
      end
      FlushW = 1'b1;
      step();
      checks++;
      if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || ResultW !== 32'h77) begin
         errors++;
         $display("FAIL stall_flush: got valid=%b we=%b res=%h, want 0 0 00000077",
                  ValidW, RegWriteW, ResultW);
      end
      FlushW = 1'b0;
      StallW = 1'b0;
      drive(1'b1, 1'b1, 5'd12, 2'b00, 3'b000, 32'hC0, 32'h0, 32'h0, 32'h0);
      step();
      StallW = 1'b1;
      rst = 1'b0;
      step();
      checks++;
      if (ValidW !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0 || ResultW !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_stall: got valid=%b we=%b rd=%0d res=%h, want 0 0 0 00000000",
                  ValidW, RegWriteW, RdW, ResultW);
      end
      rst = 1'b1;
      StallW = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rd  [4] = '{5'd1, 5'd2, 5'd0, 5'd31};
      logic [1:0]  src [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
      logic [31:0] exp [4] = '{32'h2004, 32'h000000A5, 32'h3000, 32'h4000};
      logic        we  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, rd[i], src[i], 3'b100, 32'h3000, 32'h123456A5,
               32'h2004, 32'h4000);
         step();
         checks++;
         if (ResultW !== exp[i] || RdW !== rd[i] || RegWriteW !== we[i]) begin
            errors++;
            $display("FAIL b2b[%0d]: got res=%h rd=%0d we=%b, want %h %0d %b",
                     i, ResultW, RdW, RegWriteW, exp[i], rd[i], we[i]);
         end
      end
   endtask

`ifdef WB_INSTRET_EN
   task automatic test_instret();
      rst = 1'b0;
      step();
      rst = 1'b1;
      drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 14; i++) begin
         StallW = (i == 3 || i == 8);
         FlushW = (i == 5);
         ValidM = (i != 11);
         step();
      end
      StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b1;
      checks++;
      if (InstretW !== 64'd10) begin
         errors++;
         $display("FAIL instret_count: got %0d, want 10", InstretW);
      end
      dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      checks++;
      if (InstretW !== 64'd0) begin
         errors++;
         $display("FAIL instret_wrap: got %h, want 0", InstretW);
      end
   endtask
`endif

   initial begin
      rst = 1'b0; StallW = 1'b0; FlushW = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      test_reset();
      test_load_format();
      test_source_mux();
      test_x0_suppress();
      test_stall_flush();
      test_back_to_back();
`ifdef WB_INSTRET_EN
      test_instret();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised writeback stage for the pipelined RISC-V core. Captures the MEM/WB pipeline fields on each clock edge with stall and flush control. Formats load data (byte/halfword/word extraction with sign or zero extension) and selects the result from one of four sources. Drives the register-file write port and the WB forwarding value back to the hazard unit.

## Interface
Parameters:
- WIDTH, 32, datapath width; legal values 32 and 64.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- StallW  in  1  hold the WB register contents.
- FlushW  in  1  insert a bubble into WB.
- ValidM  in  1  the MEM stage holds a real instruction.
- RegWriteM  in  1  the instruction writes rd.
- RdM  in  REG_AW  destination register index.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- Funct3M  in  3  load type.
- ALUResultM  in  WIDTH  ALU result; its low bits are the load byte offset.
- ReadDataM  in  WIDTH  raw, aligned data-memory word.
- PCPlus4M  in  WIDTH  link value.
- ImmExtM  in  WIDTH  extended immediate.
- ValidW  out  1  WB holds a real instruction.
- RegWriteW  out  1  qualified register-file write enable.
- RdW  out  REG_AW  write index.
- ResultW  out  WIDTH  write data and forwarding value.
- InstretW  out  64  retired-instruction count; present only with WB_INSTRET_EN.

## Operation
- WB register fields: valid, regwrite, rd, resultsrc, funct3, aluresult, readdata, pcplus4, immext.
- Capture priority, evaluated every edge:
  - rst low: all fields cleared to 0.
  - else FlushW: valid and regwrite cleared; all other fields are don't-care and are held.
  - else StallW: all fields held.
  - else: all fields load from the M-side inputs.
- FlushW and StallW together: flush wins.
- RegWriteW = regwrite & valid & (RdW != 0). Writes to x0 are never issued.
- Load formatting applies only when resultsrc = 01. The byte offset is aluresult[1:0] for WIDTH=32 and aluresult[2:0] for WIDTH=64.
  - 000 LB: selected byte, sign-extended.
  - 100 LBU: selected byte, zero-extended.
  - 001 LH: halfword at offset with bit 0 ignored, sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW: word at offset with bits [1:0] ignored. Passed as-is for WIDTH=32; sign-extended for WIDTH=64.
  - 110 LWU (WIDTH=64 only): same word, zero-extended.
  - 011 LD (WIDTH=64 only): full doubleword.
  - Any other code: raw readdata, unmodified.
- ResultW is a combinational mux over the registered fields: 00 aluresult, 01 formatted load, 10 pcplus4, 11 immext.
- ResultW is driven even when ValidW=0. Consumers must qualify it with RegWriteW.

## Timing
- Latency: M-side inputs reach the W outputs one edge after capture.
- ResultW settles combinationally from the registered fields in the same cycle. There is no second register stage.
- Outputs during and after reset: ValidW=0, RegWriteW=0, RdW=0, ResultW=0 (aluresult=0, resultsrc=00), InstretW=0.
- Stall: outputs stay bit-identical for every stalled cycle, and RegWriteW stays asserted if it was. Register-file writes are idempotent, so repeated writes are acceptable.
- Flush: ValidW=0 and RegWriteW=0 from the following cycle.
- A reset asserted mid-stall clears state at the next edge regardless of StallW.

## Configuration
- WB_INSTRET_EN defined:
  - A 64-bit counter increments by 1 on every edge that loads a new valid instruction (rst high, FlushW=0, StallW=0, ValidM=1).
  - The counter wraps from 2^64-1 to 0 and is cleared by rst.
  - InstretW exposes the counter.
- WB_INSTRET_EN undefined: the counter and the InstretW port are absent.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs -> all outputs 0. Release -> first valid capture appears one cycle later.
- Load formatting, WIDTH=32, ReadDataM=0x80F17F02, ResultSrcM=01:
  - LB offset 3 -> ResultW=0xFFFFFF80.
  - LBU offset 3 -> 0x00000080.
  - LH offset 2 -> 0xFFFF80F1.
  - LHU offset 1 -> 0x00007F02.
  - LW -> 0x80F17F02.
- Source mux: ALUResultM=0x10, PCPlus4M=0x104, ImmExtM=0xABCDE000 with ResultSrcM=00/10/11 -> ResultW=0x10 / 0x104 / 0xABCDE000 one cycle later.
- x0 suppression: RegWriteM=1, RdM=0, ValidM=1 -> RegWriteW=0 and ValidW=1. With RdM=5 -> RegWriteW=1 and RdW=5.
- Stall and flush: capture an instruction, then StallW=1 for 3 cycles -> outputs unchanged. Then StallW=1 and FlushW=1 together -> ValidW=0 and RegWriteW=0 next cycle.
- WB_INSTRET_EN: 10 valid captures, 2 stalls and 1 flush interleaved -> InstretW=10. Preload the counter to 2^64-1 and capture once more -> InstretW=0.
